// File: rtl/addsub_multicycle.sv
// ---------------------------------------------------------------------------
// addsub_multicycle
//
// Purpose:
//   Computes a WIDTH-bit add or subtract over several clock cycles. Each cycle
//   handles CHUNK bits, and a stored carry links one chunk to the next. Only a
//   single CHUNK-wide adder is used, whatever the value of WIDTH. Operands
//   arrive through a valid/ready handshake and results leave through another.
//   The block also produces carry, signed overflow, zero and negative flags
//   for the ALU status register.
//
// Parameters:
//   WIDTH  operand and result width in bits (default 16)
//   CHUNK  bits processed per RUN cycle (default 4); WIDTH % CHUNK must be 0
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   asynchronous, active-high reset
//   in_valid   in   operands and mode are valid
//   in_ready   out  block can accept an operation
//   mode       in   0 = add, 1 = subtract
//   a, b       in   operands (WIDTH bits)
//   cin        in   carry-in (add) or borrow-in (subtract)
//   out_valid  out  result and flags are valid
//   out_ready  in   consumer accepts the result
//   result     out  sum or difference (WIDTH bits)
//   carry      out  final carry-out; for subtract, 1 = no borrow
//   overflow   out  signed two's-complement overflow
//   zero       out  result == 0
//   negative   out  result[WIDTH-1]
//
// Optional feature:
//   ADDSUB_SATURATE_EN  When this macro is defined, a signed overflow clamps
//                       the result to the most positive or most negative
//                       value. The overflow flag is still set, and carry is
//                       the carry-out before saturation.
//
// States:
//   state | meaning
//   IDLE  | in_ready high, waiting for an operation
//   RUN   | one chunk per cycle, lowest chunk first
//   HOLD  | out_valid high, result held until out_ready
// ---------------------------------------------------------------------------
module addsub_multicycle #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             overflow,
    output logic             zero,
    output logic             negative
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

    generate
        if (CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_params
            $error("addsub_multicycle: WIDTH must be a non-zero multiple of CHUNK");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic             cy;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;     // already inverted for subtract
    logic [WIDTH-1:0] acc;       // working sum, kept apart from the result port

    logic [CHUNK-1:0] a_chunk;
    logic [CHUNK-1:0] b_chunk;
    logic [CHUNK:0]   sum;
    logic [WIDTH-1:0] acc_next;
    logic [WIDTH-1:0] final_res;
    logic             ovf;

    always_comb begin
        a_chunk  = '0;
        b_chunk  = '0;
        acc_next = acc;
        for (int k = 0; k < NCHUNK; k++) begin
            if (cnt == CW'(k)) begin
                a_chunk = a_reg[k*CHUNK +: CHUNK];
                b_chunk = b_reg[k*CHUNK +: CHUNK];
            end
        end
        sum = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CHUNK{1'b0}}, cy};
        for (int k = 0; k < NCHUNK; k++) begin
            if (cnt == CW'(k)) begin
                acc_next[k*CHUNK +: CHUNK] = sum[CHUNK-1:0];
            end
        end
        // Only meaningful on the final chunk, which is the only time it is used.
        ovf = (a_reg[WIDTH-1] == b_reg[WIDTH-1]) && (acc_next[WIDTH-1] != a_reg[WIDTH-1]);
`ifdef ADDSUB_SATURATE_EN
        if (ovf) begin
            final_res = a_reg[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                       : {1'b0, {(WIDTH-1){1'b1}}};
        end else begin
            final_res = acc_next;
        end
`else
        final_res = acc_next;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            cy        <= 1'b0;
            a_reg     <= '0;
            b_reg     <= '0;
            acc       <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            result    <= '0;
            carry     <= 1'b0;
            overflow  <= 1'b0;
            zero      <= 1'b0;
            negative  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    if (in_valid && in_ready) begin
                        // Subtract is a + ~b + ~cin, so the inversion happens once, here.
                        a_reg    <= a;
                        b_reg    <= mode ? ~b : b;
                        cy       <= mode ? ~cin : cin;
                        cnt      <= '0;
                        acc      <= '0;
                        in_ready <= 1'b0;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    acc <= acc_next;
                    cy  <= sum[CHUNK];
                    if (cnt == LAST) begin
                        cnt       <= '0;
                        result    <= final_res;
                        carry     <= sum[CHUNK];
                        overflow  <= ovf;
                        zero      <= (final_res == '0);
                        negative  <= final_res[WIDTH-1];
                        out_valid <= 1'b1;
                        state     <= HOLD;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_addsub_multicycle.sv
// Scoreboard bench for addsub_multicycle with WIDTH=16 and CHUNK=4.
module tb_addsub_multicycle;

    localparam int W = 16;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic         mode;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         carry;
    logic         overflow;
    logic         zero;
    logic         negative;

    addsub_multicycle #(.WIDTH(16), .CHUNK(4)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .mode(mode), .a(a), .b(b), .cin(cin),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .carry(carry), .overflow(overflow),
        .zero(zero), .negative(negative)
    );

    typedef struct packed {
        logic [W-1:0] res;
        logic         c;
        logic         v;
        logic         z;
        logic         n;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Monitor: compares each presented result against the head of the queue.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_output", 32'(result), 32'hDEAD);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("result",   32'(result),   32'(e.res));
                chk("carry",    32'(carry),    32'(e.c));
                chk("overflow", 32'(overflow), 32'(e.v));
                chk("zero",     32'(zero),     32'(e.z));
                chk("negative", 32'(negative), 32'(e.n));
            end
        end
    end

    // Call at posedge+1 while in IDLE. Returns once out_valid is seen, after
    // measuring the latency; the handshake is left to the caller.
    task automatic issue(input logic m, input logic [W-1:0] va, input logic [W-1:0] vb,
                         input logic vc, input exp_t e);
        int cyc;
        chk("in_ready_idle", 32'(in_ready), 32'd1);
        mode = m; a = va; b = vb; cin = vc; in_valid = 1'b1;
        sb.push_back(e);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        // Change the operands after the accept edge; the result must not move.
        a = 16'(($urandom));
        b = 16'(($urandom));
        mode = ~m; cin = ~vc;
        cyc = 0;
        while (!out_valid && cyc < 20) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        chk("latency", 32'(cyc), 32'd4);
    endtask

    task automatic run_op(input logic m, input logic [W-1:0] va, input logic [W-1:0] vb,
                          input logic vc, input exp_t e);
        issue(m, va, vb, vc, e);
        @(posedge clk);
        #1;
        chk("back_to_idle", 32'({out_valid, in_ready}), 32'b01);
    endtask

    initial begin
        exp_t e;
        logic [W-1:0] held;
        int wait_cyc;

        rst = 1'b1; in_valid = 1'b0; mode = 1'b0; a = '0; b = '0; cin = 1'b0; out_ready = 1'b1;
        #1;
        chk("reset_outputs", 32'({in_ready, out_valid, result, carry, overflow, zero, negative}),
            32'({1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0}));
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        run_op(1'b0, 16'h1234, 16'h0FFF, 1'b0, '{16'h2233, 1'b0, 1'b0, 1'b0, 1'b0});
        run_op(1'b1, 16'h001E, 16'h0003, 1'b0, '{16'h001B, 1'b1, 1'b0, 1'b0, 1'b0});
        run_op(1'b1, 16'h000E, 16'h001E, 1'b0, '{16'hFFF0, 1'b0, 1'b0, 1'b0, 1'b1});
`ifdef ADDSUB_SATURATE_EN
        run_op(1'b0, 16'h7FFF, 16'h0001, 1'b0, '{16'h7FFF, 1'b0, 1'b1, 1'b0, 1'b0});
        run_op(1'b1, 16'h8000, 16'h0001, 1'b0, '{16'h8000, 1'b1, 1'b1, 1'b0, 1'b1});
`else
        run_op(1'b0, 16'h7FFF, 16'h0001, 1'b0, '{16'h8000, 1'b0, 1'b1, 1'b0, 1'b1});
        run_op(1'b1, 16'h8000, 16'h0001, 1'b0, '{16'h7FFF, 1'b1, 1'b1, 1'b0, 1'b0});
`endif
        run_op(1'b1, 16'h0000, 16'h0000, 1'b1, '{16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b1});
        run_op(1'b1, 16'h0000, 16'h0000, 1'b0, '{16'h0000, 1'b1, 1'b0, 1'b1, 1'b0});
        run_op(1'b0, 16'hFFFF, 16'h0001, 1'b0, '{16'h0000, 1'b1, 1'b0, 1'b1, 1'b0});
        run_op(1'b0, 16'h00FF, 16'h0000, 1'b1, '{16'h0100, 1'b0, 1'b0, 1'b0, 1'b0});

        // Back-pressure: the result must stay in HOLD for 5 cycles.
        out_ready = 1'b0;
        issue(1'b0, 16'h1111, 16'h2222, 1'b1, '{16'h3334, 1'b0, 1'b0, 1'b0, 1'b0});
        held = result;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk("hold_result", 32'(result), 32'(held));
            chk("hold_flags", 32'({out_valid, in_ready}), 32'b10);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("hold_release", 32'({out_valid, in_ready}), 32'b01);

        // Reset during the second RUN cycle aborts the operation.
        chk("in_ready_pre_abort", 32'(in_ready), 32'd1);
        mode = 1'b0; a = 16'hABCD; b = 16'h1111; cin = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("abort_outputs", 32'({in_ready, out_valid, result, carry, overflow, zero, negative}),
            32'({1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0}));
        @(posedge clk);
        #1;
        rst = 1'b0;
        wait_cyc = 0;
        while (wait_cyc < 8) begin
            @(posedge clk);
            #1;
            if (out_valid) chk("abort_no_output", 32'(out_valid), 32'd0);
            wait_cyc++;
        end
`ifdef ADDSUB_SATURATE_EN
        e = '{16'h7FFF, 1'b0, 1'b1, 1'b0, 1'b0};
`else
        e = '{16'h8000, 1'b0, 1'b1, 1'b0, 1'b1};
`endif
        run_op(1'b0, 16'h4000, 16'h4000, 1'b0, e);

        repeat (2) @(posedge clk);
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
